mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the MIPS pipeline; owns the HI/LO registers.
- Accepts an operation from EX on `start` and raises `busy` for a programmable latency.
- Commits HI/LO at the end of that latency. The hazard unit stalls any HI/LO consumer while `busy`=1.
- Supersedes mod_mult:
  - width generic;
  - separate mult/div latencies;
  - adds divide, MTHI/MTLO, and accumulate ops (MADD/MSUB);
  - adds a `done` pulse.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles `busy` stays high for multiply and accumulate ops (>=1).
- DIV_CYCLES, 10, cycles `busy` stays high for divide ops (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a  in  WIDTH  operand rs
- b  in  WIDTH  operand rt
- op  in  4  operation code (see Behaviour)
- start  in  1  launch request, sampled at the clk edge
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse on the edge that commits HI/LO
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: clk is single clock; rst_n asynchronous, active-low. While rst_n=0: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation discards the pending result.
- Opcodes:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
  - 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU
  - 10-15 no-op (ignored, no busy, no done)
- FSM states: IDLE, RUN.
- IDLE, start=1, op in {MULT,MULTU,MADD..MSUBU}, at edge k:
  - latch the result into pending regs;
  - counter=MULT_CYCLES;
  - go to RUN.
- IDLE, start=1, op in {DIV,DIVU}: same as above with counter=DIV_CYCLES.
- IDLE, start=1, MTHI/MTLO: hi<=a (MTHI) or lo<=a (MTLO) at edge k; no busy, done=1 for one cycle.
- RUN: counter decrements each edge. On the edge where it reaches 0:
  - hi/lo <= pending;
  - done=1 for the following cycle;
  - state=IDLE, busy=0.
  - So busy is high for exactly N cycles (edges k+1..k+N) and the result is visible after edge k+N.
- busy = (state==RUN), registered.
- start while busy=1 is ignored entirely, including MTHI/MTLO. The pipeline must stall instead.
- Back-to-back: start is accepted in the same cycle busy falls, i.e. the cycle after the commit edge.
- hi/lo hold their old values throughout RUN.
- Arithmetic:
  - MULT/MULTU: 2*WIDTH product of signed/unsigned a*b; hi=upper half, lo=lower half.
  - MADD/MADDU: {hi,lo} + product. MSUB/MSUBU: {hi,lo} - product. Both use the {hi,lo} value at the start edge, wrap modulo 2^(2*WIDTH).
  - DIV/DIVU: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
- Division boundary cases:
  - b=0: lo=all ones, hi=a. Latency unchanged.
  - Signed DIV of INT_MIN by -1: lo=INT_MIN, hi=0.
- Operands are captured at the start edge; later changes to a/b/op have no effect.

Decomposition:
- Shared package mdu_pkg holds:
  - opcode localparams (OP_MULT .. OP_MSUBU);
  - state encoding (ST_IDLE, ST_RUN).
- One sub-module, mdu_divider: combinational signed/unsigned WIDTH-bit divide with the zero and overflow rules above.
- Product and accumulate logic stay in mdu_unit.

Test Plan:
- MULT a=0xFFFFFFFF b=0x0000FFFF:
  - busy high for exactly 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFF0001, done single pulse.
- MULTU with the same operands -> hi=0x0000FFFE, lo=0xFFFF0001 after 5 cycles.
- DIV a=0xFFFFFFF9 (-7) b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO a=0xFFFFFFFF, then MADDU a=1 b=1:
  - lo=0xFFFFFFFF after one edge, busy stays 0;
  - MADDU gives hi=1, lo=0;
  - a second start pulsed mid-RUN is ignored (hi/lo unchanged by it, busy length unchanged).
- Reset mid-RUN:
  - assert rst_n=0 at cycle 3 of a MULT -> busy=0, hi=lo=0 immediately, without waiting for a clock edge;
  - no done pulse after release.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared opcode and state encodings for the multiply/divide unit.
// Contents : OP_* operation codes (4 bits), state_t FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
// Module   : mdu_divider
// Purpose  : Combinational WIDTH-bit signed/unsigned divide. Quotient truncates
//            toward zero, remainder takes the sign of the dividend.
//            Divide by zero yields quotient all-ones, remainder = dividend.
// Ports    : dividend, divisor (in, WIDTH), is_signed (in, 1),
//            quotient, remainder (out, WIDTH)
// Revision : 1.0 - initial release
// ============================================================================
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;

    // Divide magnitudes, then restore signs. INT_MIN / -1 needs no special
    // case: |INT_MIN| is representable unsigned, the quotient magnitude is
    // 2^(WIDTH-1) and both signs cancel, giving INT_MIN with remainder 0.
    always_comb begin
        w_a_neg   = is_signed & dividend[WIDTH-1];
        w_b_neg   = is_signed & divisor[WIDTH-1];
        w_a_mag   = w_a_neg ? -dividend : dividend;
        w_b_mag   = w_b_neg ? -divisor  : divisor;
        w_q_mag   = '0;
        w_r_mag   = '0;
        quotient  = '1;
        remainder = dividend;
        if (divisor != '0) begin
            w_q_mag   = w_a_mag / w_b_mag;
            w_r_mag   = w_a_mag % w_b_mag;
            quotient  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
            remainder = w_a_neg ? -w_r_mag : w_r_mag;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : Multi-cycle multiply/divide unit owning the HI/LO registers.
//            A launched op holds busy for MULT_CYCLES or DIV_CYCLES cycles and
//            then commits HI/LO with a one-cycle done pulse. MTHI/MTLO write
//            immediately (no busy) and also pulse done.
// Ports    : clk, rst_n (async active-low), a, b (WIDTH), op (4), start,
//            busy, done, hi, lo (WIDTH)
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic [WIDTH-1:0]       r_pend_hi;
    logic [WIDTH-1:0]       r_pend_lo;
    logic                   r_done;

    logic                   w_is_mul;
    logic                   w_is_div;
    logic                   w_mul_signed;
    logic [2*WIDTH-1:0]     w_ext_a;
    logic [2*WIDTH-1:0]     w_ext_b;
    logic [2*WIDTH-1:0]     w_prod;
    logic [2*WIDTH-1:0]     w_mul_res;
    logic [2*WIDTH-1:0]     w_result;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem;
    logic                   w_launch;
    logic                   w_commit;
    logic                   w_mt_hi;
    logic                   w_mt_lo;

    // ---------------------------------------------------------------- datapath
    // One 2*WIDTH multiplier serves signed and unsigned: the low 2*WIDTH bits
    // of the product of sign-extended operands equal the signed product.
    always_comb begin
        w_is_mul     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                       (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
        w_is_div     = (op == OP_DIV) || (op == OP_DIVU);
        w_mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        w_ext_a      = w_mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        w_ext_b      = w_mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        w_prod       = w_ext_a * w_ext_b;
        if ((op == OP_MADD) || (op == OP_MADDU)) begin
            w_mul_res = {r_hi, r_lo} + w_prod;
        end else if ((op == OP_MSUB) || (op == OP_MSUBU)) begin
            w_mul_res = {r_hi, r_lo} - w_prod;
        end else begin
            w_mul_res = w_prod;
        end
        w_result = w_is_div ? {w_rem, w_quo} : w_mul_res;
    end

    mdu_divider #(
        .WIDTH     (WIDTH)
    ) u_divider (
        .dividend  (a),
        .divisor   (b),
        .is_signed (op == OP_DIV),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_commit     = 1'b0;
        w_mt_hi      = 1'b0;
        w_mt_lo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_is_mul || w_is_div) begin
                        w_launch     = 1'b1;
                        w_next_state = ST_RUN;
                    end
                    w_mt_hi = (op == OP_MTHI);
                    w_mt_lo = (op == OP_MTLO);
                end
            end
            ST_RUN: begin
                // Commit on the edge where the counter reaches zero.
                if (r_cnt == c_CNT_W'(1)) begin
                    w_commit     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------- counter and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_commit | w_mt_hi | w_mt_lo;
            if (w_launch) begin
                r_pend_hi <= w_result[2*WIDTH-1:WIDTH];
                r_pend_lo <= w_result[WIDTH-1:0];
                r_cnt     <= w_is_div ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (w_commit) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            if (w_mt_hi) begin
                r_hi <= a;
            end
            if (w_mt_lo) begin
                r_lo <= a;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_unit
// Purpose  : Self-checking bench for mdu_unit (WIDTH=32, 5/10 cycle latency).
//            Expected results are queued when an op is launched and compared
//            when the unit signals completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

    localparam logic [3:0] T_MULT  = 4'd0;
    localparam logic [3:0] T_MULTU = 4'd1;
    localparam logic [3:0] T_DIV   = 4'd2;
    localparam logic [3:0] T_DIVU  = 4'd3;
    localparam logic [3:0] T_MTHI  = 4'd4;
    localparam logic [3:0] T_MTLO  = 4'd5;
    localparam logic [3:0] T_MADD  = 4'd6;
    localparam logic [3:0] T_MADDU = 4'd7;
    localparam logic [3:0] T_MSUB  = 4'd8;
    localparam int         T_MC    = 5;
    localparam int         T_DC    = 10;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t scb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mdu_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (T_MC),
        .DIV_CYCLES  (T_DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .op    (op),
        .start (start),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: holds start for one rising edge, then scrambles the
    // operand inputs so late changes would corrupt a design that failed to
    // capture them.
    task automatic drive_start(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 4'($urandom_range(0, 15));
    endtask

    task automatic push_exp(input string nm, input logic [31:0] h, input logic [31:0] l, input int cyc);
        exp_t e;
        e.name   = nm;
        e.hi     = h;
        e.lo     = l;
        e.cycles = cyc;
        scb.push_back(e);
    endtask

    // Counts negedges with busy high; returns at the first negedge with busy low.
    task automatic wait_done(output int cycles, output bit timeout);
        cycles  = 0;
        timeout = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ctrl: busy/done got %b%b want 00", busy, done);
        end
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [3:0] ops [2];
        int   cyc;
        bit   to;
        exp_t e;
        ops[0] = T_MULT;
        ops[1] = T_MULTU;
        push_exp("mult",  32'hFFFFFFFF, 32'hFFFF0001, T_MC);
        push_exp("multu", 32'h0000FFFE, 32'hFFFF0001, T_MC);
        for (int i = 0; i < 2; i++) begin
            drive_start(ops[i], 32'hFFFFFFFF, 32'h0000FFFF);
            wait_done(cyc, to);
            e = scb.pop_front();
            n_cmp++;
            if (to || cyc != e.cycles) begin
                n_bad++;
                $display("FAIL %s busy_len: got %0d want %0d", e.name, cyc, e.cycles);
            end
            n_cmp++;
            if (done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin
                n_bad++;
                $display("FAIL %s result: got done=%b hi=%h lo=%h want done=1 hi=%h lo=%h",
                         e.name, done, hi, lo, e.hi, e.lo);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL %s done_pulse: got %b want 0 second cycle", e.name, done);
            end
        end
    endtask

    task automatic test_div();
        logic [3:0]  ops [3];
        logic [31:0] xs  [3];
        logic [31:0] ys  [3];
        int   cyc;
        bit   to;
        exp_t e;
        ops[0] = T_DIV;  xs[0] = 32'hFFFFFFF9; ys[0] = 32'd2;
        ops[1] = T_DIVU; xs[1] = 32'd5;        ys[1] = 32'd0;
        ops[2] = T_DIV;  xs[2] = 32'h80000000; ys[2] = 32'hFFFFFFFF;
        push_exp("div_neg7_by2", 32'hFFFFFFFF, 32'hFFFFFFFD, T_DC);
        push_exp("divu_by0",     32'h00000005, 32'hFFFFFFFF, T_DC);
        push_exp("div_ovf",      32'h00000000, 32'h80000000, T_DC);
        for (int i = 0; i < 3; i++) begin
            drive_start(ops[i], xs[i], ys[i]);
            wait_done(cyc, to);
            e = scb.pop_front();
            n_cmp++;
            if (to || cyc != e.cycles) begin
                n_bad++;
                $display("FAIL %s busy_len: got %0d want %0d", e.name, cyc, e.cycles);
            end
            n_cmp++;
            if (done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin
                n_bad++;
                $display("FAIL %s result: got done=%b hi=%h lo=%h want done=1 hi=%h lo=%h",
                         e.name, done, hi, lo, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_mt_acc();
        int   cyc;
        bit   held_ok;
        exp_t e;
        drive_start(T_MTHI, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b1 || hi !== 32'h0) begin
            n_bad++;
            $display("FAIL mthi: got busy=%b done=%b hi=%h want 0 1 00000000", busy, done, hi);
        end
        drive_start(T_MTLO, 32'hFFFFFFFF, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b1 || lo !== 32'hFFFFFFFF) begin
            n_bad++;
            $display("FAIL mtlo: got busy=%b done=%b lo=%h want 0 1 ffffffff", busy, done, lo);
        end
        push_exp("maddu", 32'h1, 32'h0, T_MC);
        drive_start(T_MADDU, 32'h1, 32'h1);
        // Pulse a second start (MTHI) mid-run; it must be ignored.
        cyc     = 0;
        held_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) break;
            cyc++;
            if (hi !== 32'h0 || lo !== 32'hFFFFFFFF) held_ok = 1'b0;
            if (cyc == 2) begin
                op    = T_MTHI;
                a     = 32'hDEADBEEF;
                start = 1'b1;
            end
        end
        e = scb.pop_front();
        n_cmp++;
        if (!held_ok) begin
            n_bad++;
            $display("FAIL maddu_hold: hi/lo changed during run, got %b want 1", held_ok);
        end
        n_cmp++;
        if (cyc != e.cycles) begin
            n_bad++;
            $display("FAIL maddu busy_len: got %0d want %0d", cyc, e.cycles);
        end
        n_cmp++;
        if (done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin
            n_bad++;
            $display("FAIL maddu result: got done=%b hi=%h lo=%h want done=1 hi=%h lo=%h",
                     done, hi, lo, e.hi, e.lo);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h1) begin
            n_bad++;
            $display("FAIL ignored_start: got busy=%b done=%b hi=%h want 0 0 00000001", busy, done, hi);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        bit   to;
        exp_t e;
        push_exp("b2b_multu", 32'h0, 32'd12, T_MC);
        push_exp("b2b_divu",  32'd2, 32'd14, T_DC);
        drive_start(T_MULTU, 32'd3, 32'd4);
        wait_done(cyc, to);
        e = scb.pop_front();
        n_cmp++;
        if (to || cyc != e.cycles || hi !== e.hi || lo !== e.lo) begin
            n_bad++;
            $display("FAIL %s: got cyc=%0d hi=%h lo=%h want cyc=%0d hi=%h lo=%h",
                     e.name, cyc, hi, lo, e.cycles, e.hi, e.lo);
        end
        // Launch in the very cycle busy fell.
        drive_start(T_DIVU, 32'd100, 32'd7);
        wait_done(cyc, to);
        e = scb.pop_front();
        n_cmp++;
        if (to || cyc != e.cycles || done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin
            n_bad++;
            $display("FAIL %s: got cyc=%0d done=%b hi=%h lo=%h want cyc=%0d done=1 hi=%h lo=%h",
                     e.name, cyc, done, hi, lo, e.cycles, e.hi, e.lo);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops [6];
        logic [31:0] m_hi, m_lo, x, y, q, r;
        logic [63:0] p, acc;
        int   cyc;
        bit   to;
        exp_t e;
        ops[0] = T_MULT; ops[1] = T_MULTU; ops[2] = T_DIV;
        ops[3] = T_DIVU; ops[4] = T_MADD;  ops[5] = T_MSUB;
        m_hi = 32'h12345678;
        m_lo = 32'h9ABCDEF0;
        drive_start(T_MTHI, m_hi, 32'h0);
        @(negedge clk);
        drive_start(T_MTLO, m_lo, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_bad++;
            $display("FAIL rand_seed_hilo: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, m_hi, m_lo);
        end
        for (int n = 0; n < 12; n++) begin
            logic [3:0] o;
            o = ops[n % 6];
            x = $urandom;
            y = $urandom;
            if (n >= 6) y = y >> $urandom_range(0, 28);
            if (y == 32'h0) y = 32'd3;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd2;
            acc = {m_hi, m_lo};
            if (o == T_DIV || o == T_DIVU) begin
                if (o == T_DIV) begin
                    q = 32'($signed(x) / $signed(y));
                    r = 32'($signed(x) % $signed(y));
                end else begin
                    q = x / y;
                    r = x % y;
                end
                m_hi = r;
                m_lo = q;
                push_exp("rand_div", m_hi, m_lo, T_DC);
            end else begin
                if (o == T_MULTU) p = {32'h0, x} * {32'h0, y};
                else              p = 64'(longint'($signed(x)) * longint'($signed(y)));
                if (o == T_MADD)      acc = acc + p;
                else if (o == T_MSUB) acc = acc - p;
                else                  acc = p;
                m_hi = acc[63:32];
                m_lo = acc[31:0];
                push_exp("rand_mul", m_hi, m_lo, T_MC);
            end
            drive_start(o, x, y);
            wait_done(cyc, to);
            e = scb.pop_front();
            n_cmp++;
            if (to || cyc != e.cycles || done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin
                n_bad++;
                $display("FAIL %s op=%0d a=%h b=%h: got cyc=%0d hi=%h lo=%h want cyc=%0d hi=%h lo=%h",
                         e.name, o, x, y, cyc, hi, lo, e.cycles, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit quiet;
        drive_start(T_MULT, 32'h7, 32'h9);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL reset_discard: activity after reset got %b want 1", quiet);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_acc();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
